// File: rtl/gpio_port.sv
// NPORTS x 8-bit GPIO with direction, atomic set/clear and
// synchronised pin-change capture into a write-1-to-clear status register.
module gpio_port #(
  parameter int NPORTS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                we,
  input  logic [4:0]          addr,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  input  logic [8*NPORTS-1:0] gpio_i,
  output logic [8*NPORTS-1:0] gpio_o,
  output logic [8*NPORTS-1:0] gpio_oe,
  output logic                irq
);

  localparam int W = 8 * NPORTS;

  logic [NPORTS-1:0][7:0] out_q, out_d;
  logic [NPORTS-1:0][7:0] dir_q, dir_d;
  logic [NPORTS-1:0][7:0] ren_q, ren_d;
  logic [NPORTS-1:0][7:0] fen_q, fen_d;
  logic [NPORTS-1:0][7:0] stat_q, stat_d;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] s_last, rise, fall;
  logic [7:0]   dout_q, dout_d;
  logic         wr, rd;
  logic [2:0]   reg_a;

  assign wr     = cs & we;
  assign rd     = cs & ~we;
  assign reg_a  = addr[2:0];
  assign s_last = sync_q[SYNC_STAGES-1];
  assign rise   = s_last & ~prev_q;
  assign fall   = ~s_last & prev_q;

  always_comb begin
    sync_d = sync_q;
    sync_d[0] = gpio_i;
    for (int s = 1; s < SYNC_STAGES; s++)
      sync_d[s] = sync_q[s-1];
    prev_d = s_last;
  end

  // Edge set is ORed in after the W1C mask, so a coincident edge wins.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ren_d  = ren_q;
    fen_d  = fen_q;
    stat_d = stat_q;
    for (int p = 0; p < NPORTS; p++) begin
      if (wr && addr[4:3] == 2'(p)) begin
        case (reg_a)
          3'd0: out_d[p] = din;
          3'd1: dir_d[p] = din;
          3'd3: ren_d[p] = din;
          3'd4: fen_d[p] = din;
          3'd6: out_d[p] = out_q[p] | din;
          3'd7: out_d[p] = out_q[p] & ~din;
          default: ;
        endcase
      end
      stat_d[p] = (stat_q[p] &
                   ~((wr && addr[4:3] == 2'(p) && reg_a == 3'd5) ? din : 8'h00))
                | (rise[8*p +: 8] & ren_q[p])
                | (fall[8*p +: 8] & fen_q[p]);
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (rd) begin
      dout_d = 8'h00;
      for (int p = 0; p < NPORTS; p++) begin
        if (addr[4:3] == 2'(p)) begin
          case (reg_a)
            3'd0:    dout_d = out_q[p];
            3'd1:    dout_d = dir_q[p];
            3'd2:    dout_d = s_last[8*p +: 8];
            3'd3:    dout_d = ren_q[p];
            3'd4:    dout_d = fen_q[p];
            3'd5:    dout_d = stat_q[p];
            default: dout_d = 8'h00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      ren_q  <= '0;
      fen_q  <= '0;
      stat_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      dout_q <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ren_q  <= ren_d;
      fen_q  <= fen_d;
      stat_q <= stat_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      dout_q <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq     = |stat_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: vector table for register access,
// hand-written sequences for edge capture, collision and reset.
module tb_gpio_port;

  logic        clk, rst, cs, we;
  logic [4:0]  addr;
  logic [7:0]  din, dout;
  logic [15:0] gpio_i, gpio_o, gpio_oe;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] rexp;
    logic [7:0] oexp;
    logic [7:0] eexp;
  } vec_t;

  vec_t tbl[17];

  gpio_port #(.NPORTS(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cs = 1; we = 1; addr = a; din = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    cs = 1; we = 0; addr = a;
    sb.push_back(e);
    @(negedge clk);
    cs = 0;
    chk($sformatf("rd %02h", a), {8'h00, dout}, {8'h00, sb.pop_front()});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'h00, 8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[1]  = '{1'b1, 5'h01, 8'h0F, 8'h00, 8'hA5, 8'h0F};
    tbl[2]  = '{1'b0, 5'h00, 8'h00, 8'hA5, 8'hA5, 8'h0F};
    tbl[3]  = '{1'b1, 5'h06, 8'h50, 8'h00, 8'hF5, 8'h0F};
    tbl[4]  = '{1'b0, 5'h00, 8'h00, 8'hF5, 8'hF5, 8'h0F};
    tbl[5]  = '{1'b1, 5'h07, 8'h81, 8'h00, 8'h74, 8'h0F};
    tbl[6]  = '{1'b0, 5'h00, 8'h00, 8'h74, 8'h74, 8'h0F};
    tbl[7]  = '{1'b0, 5'h06, 8'h00, 8'h00, 8'h74, 8'h0F};
    tbl[8]  = '{1'b0, 5'h07, 8'h00, 8'h00, 8'h74, 8'h0F};
    tbl[9]  = '{1'b0, 5'h01, 8'h00, 8'h0F, 8'h74, 8'h0F};
    tbl[10] = '{1'b1, 5'h02, 8'hFF, 8'h00, 8'h74, 8'h0F};
    tbl[11] = '{1'b1, 5'h10, 8'h03, 8'h00, 8'h74, 8'h0F};
    tbl[12] = '{1'b1, 5'h11, 8'h03, 8'h00, 8'h74, 8'h0F};
    tbl[13] = '{1'b0, 5'h10, 8'h00, 8'h00, 8'h74, 8'h0F};
    tbl[14] = '{1'b0, 5'h11, 8'h00, 8'h00, 8'h74, 8'h0F};
    tbl[15] = '{1'b0, 5'h12, 8'h00, 8'h00, 8'h74, 8'h0F};
    tbl[16] = '{1'b0, 5'h08, 8'h00, 8'h00, 8'h74, 8'h0F};

    rst = 1; cs = 0; we = 0; addr = '0; din = '0;
    gpio_i = 16'hFFFF;
    repeat (3) tick();
    chk("rst gpio_o", gpio_o, 16'h0000);
    chk("rst gpio_oe", gpio_oe, 16'h0000);
    chk("rst irq", {15'h0, irq}, 16'h0000);
    chk("rst dout", {8'h00, dout}, 16'h0000);
    rst = 0;
    repeat (3) tick();
    for (int r = 0; r < 8; r++)
      rd(5'(r), (r == 2) ? 8'hFF : 8'h00);
    chk("post rst irq", {15'h0, irq}, 16'h0000);

    gpio_i = 16'h0200;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      else rd(tbl[i].a, tbl[i].rexp);
      chk($sformatf("vec%0d gpio_o", i), gpio_o, {8'h00, tbl[i].oexp});
      chk($sformatf("vec%0d gpio_oe", i), gpio_oe, {8'h00, tbl[i].eexp});
    end

    wr(5'h0B, 8'h01);
    wr(5'h0C, 8'h02);
    gpio_i[8] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("irq lat e%0d", k - 1), {15'h0, irq},
          {15'h0, (k == 3)});
    end
    rd(5'h0D, 8'h01);
    gpio_i[9] = 1'b0;
    repeat (4) tick();
    rd(5'h0D, 8'h03);
    wr(5'h0D, 8'h01);
    rd(5'h0D, 8'h02);
    chk("irq partial w1c", {15'h0, irq}, 16'h0001);
    wr(5'h0D, 8'h02);
    chk("irq cleared", {15'h0, irq}, 16'h0000);
    rd(5'h0D, 8'h00);

    gpio_i[8] = 1'b0;
    repeat (4) tick();
    gpio_i[8] = 1'b1;
    repeat (4) tick();
    rd(5'h0D, 8'h01);
    gpio_i[8] = 1'b0;
    repeat (4) tick();
    gpio_i[8] = 1'b1;
    tick();
    tick();
    wr(5'h0D, 8'h01);
    chk("collide irq", {15'h0, irq}, 16'h0001);
    rd(5'h0D, 8'h01);
    wr(5'h0D, 8'h01);
    chk("collide clr irq", {15'h0, irq}, 16'h0000);

    gpio_i[0] = 1'b1;
    repeat (4) tick();
    chk("disabled irq", {15'h0, irq}, 16'h0000);
    rd(5'h05, 8'h00);

    gpio_i[7:0] = 8'h00;
    repeat (4) tick();
    wr(5'h03, 8'hFF);
    gpio_i[7:0] = 8'hFF;
    repeat (4) tick();
    rd(5'h05, 8'hFF);
    chk("pre rst irq", {15'h0, irq}, 16'h0001);
    wr(5'h00, 8'hFF);
    wr(5'h01, 8'hFF);
    chk("pre rst gpio_o", gpio_o, 16'h00FF);
    cs = 1; we = 0; addr = 5'h05;
    #2 rst = 1;
    #1;
    chk("async irq", {15'h0, irq}, 16'h0000);
    chk("async gpio_o", gpio_o, 16'h0000);
    chk("async gpio_oe", gpio_oe, 16'h0000);
    chk("async dout", {8'h00, dout}, 16'h0000);
    cs = 0;
    tick();
    tick();
    rst = 0;
    repeat (4) tick();
    chk("post async irq", {15'h0, irq}, 16'h0000);
    rd(5'h05, 8'h00);
    rd(5'h03, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised GPIO peripheral for the 6502 system bus: NPORTS independent 8-bit ports, each with an output latch, per-bit direction and a synchronised pin input. Each port also has rising/falling edge interrupt capture with write-1-to-clear status. It occupies one 256 B page of the I/O decode at F2xx. It replaces the fixed 8-in/8-out GPIO register and adds tristate control, atomic set/clear, and pin-change IRQs that are ORed into CPU_IRQ.

## Interface
- NPORTS, 2, number of 8-bit ports, legal 1..4
- SYNC_STAGES, 2, input synchroniser depth, legal 2..3
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cs  in  1  chip select from the address decode
- we  in  1  write enable, high = write
- addr  in  5  register address, port = addr[4:3], register = addr[2:0]
- din  in  8  CPU write data
- dout  out  8  registered read data
- gpio_i  in  8*NPORTS  pad inputs, asynchronous
- gpio_o  out  8*NPORTS  output latch values
- gpio_oe  out  8*NPORTS  output enables, 1 = drive
- irq  out  1  interrupt request, level, high = pending

## Operation
- Per-port registers at addr[2:0]:
  - 0 OUT (R/W): output latch.
  - 1 DIR (R/W): 1 = output.
  - 2 PIN (RO): synchronised pad value.
  - 3 RISE_EN (R/W).
  - 4 FALL_EN (R/W).
  - 5 STAT (R, W1C).
  - 6 OUT_SET (WO, W1S on OUT, reads 0).
  - 7 OUT_CLR (WO, W1C on OUT, reads 0).
- gpio_o = OUT; gpio_oe = DIR. PIN shows the pad value regardless of DIR, so output bits read back their own drive.
- Each pin passes through SYNC_STAGES flops (s_last), plus one more flop (s_prev).
  - rise[i] = s_last & ~s_prev; fall[i] = ~s_last & s_prev.
- STAT[i] next = (STAT[i] & ~w1c[i]) | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - w1c is din on a write to register 5 of that port, else 0.
  - If an edge and a W1C of the same bit coincide, set wins.
- Clearing RISE_EN/FALL_EN does not clear STAT.
- irq = OR of all STAT bits of all implemented ports, combinational from registers, no glitch path from gpio_i.
- If OUT is written, or OUT_SET and OUT_CLR hit, in a cycle, only the addressed register acts (one access per cycle).
- Port index >= NPORTS: writes ignored, reads return 8'h00.
- Writes to PIN are ignored.

## Timing
- Reset (asynchronous): OUT, DIR, RISE_EN, FALL_EN, STAT, synchroniser and s_prev all 0; gpio_o = 0, gpio_oe = 0, dout = 8'h00, irq = 0.
  - A pad held high through reset yields a rise event after release. It is harmless because RISE_EN = 0.
- Write: takes effect at the clk edge where cs & we. The new value is visible on gpio_o/gpio_oe after that edge.
- Read: dout loads at the edge where cs & ~we. It is valid the following cycle and holds until the next read; it never changes on writes or idle cycles. This matches the CPU_DI mux, which selects the peripheral one cycle after the address.
- Read of STAT returns the pre-edge value; a same-edge STAT set appears on the next read.
- Pin-to-STAT latency: a pad change settled before edge 0 reaches s_last after edge SYNC_STAGES-1, STAT after edge SYNC_STAGES, and irq is high in the same cycle.
  - With SYNC_STAGES = 2 that is 3 edges, counting edge 0.
- Pin-to-PIN read latency: a read at edge SYNC_STAGES returns the new value.
- Pulses shorter than one clk period may be missed. Toggles every clk at s_last set both rise and fall.
- irq deasserts the cycle after the W1C write edge that clears the last set bit, unless a new edge sets a bit at that same edge.
- Asynchronous reset mid-read or mid-write discards the access; all state returns to reset values immediately.

## Test plan
- Reset: hold rst, drive gpio_i = all ones -> gpio_o = 0, gpio_oe = 0, irq = 0, dout = 00. After release, reads of all registers of port 0 = 00, except PIN = FF.
- Direction/latch: write OUT(p0) = A5, DIR(p0) = 0F -> gpio_o[7:0] = A5, gpio_oe[7:0] = 0F. Write OUT_SET(p0) = 50 -> OUT reads F5. Write OUT_CLR(p0) = 81 -> OUT reads 74. Reads of registers 6 and 7 = 00.
- Edge IRQ: RISE_EN(p1) = 01, FALL_EN(p1) = 02. Drive gpio_i[8] 0->1 -> STAT(p1) = 01 and irq = 1 exactly 3 edges after the change (SYNC_STAGES = 2). Drive gpio_i[9] 1->0 -> STAT = 03. Write STAT = 01 -> STAT = 02, irq stays 1. Write 02 -> irq = 0 next cycle.
- Collision: time a W1C of STAT bit 0 on the same edge as a new qualified rising edge on that bit -> STAT bit 0 stays 1, irq stays 1.
- Unmapped/disabled: NPORTS = 2, write 3 to address 10h-17h -> no output change, reads 00. Edge on a pin with both enables 0 -> STAT unchanged, irq = 0.
- Reset mid-operation: with STAT = FF, irq = 1, OUT = FF, assert rst asynchronously between edges -> irq, gpio_o, gpio_oe go to 0 without waiting for clk. After release, no STAT set from pads already high.
